// File: rtl/cp0_timer_irq.sv
// CP0 Count/Compare timer with prescaler, NUM_CMP compare channels (optional
// periodic reload) and synchronised hardware interrupt lines feeding Cause.IP.
module cp0_timer_irq #(
    parameter int NUM_CMP     = 2,
    parameter int COUNT_DIV   = 2,
    parameter int NUM_HW_INT  = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wen,
    input  logic [4:0]            reg_num,
    input  logic [2:0]            sel,
    input  logic [31:0]           reg_in,
    output logic [31:0]           reg_out,
    output logic                  reg_hit,
    input  logic [NUM_HW_INT-1:0] hw_int,
    input  logic [1:0]            sw_ip,
    input  logic [7:0]            status_im,
    input  logic                  status_ie,
    input  logic                  status_exl,
    output logic [7:0]            ip_out,
    output logic                  ti,
    output logic                  int_req
);

    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [31:0]           count_q, count_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [31:0]           compare_q  [NUM_CMP];
    logic [31:0]           compare_d  [NUM_CMP];
    logic [31:0]           interval_q [NUM_CMP];
    logic [31:0]           interval_d [NUM_CMP];
    logic [NUM_CMP-1:0]    enable_q, enable_d;
    logic [NUM_CMP-1:0]    pending_q, pending_d;
    logic                  freeze_q, freeze_d;
    logic [NUM_HW_INT-1:0] sync_q [SYNC_STAGES];
    logic [7:0]            ip_q, ip_d;

    logic                  sel_count, sel_ctrl, count_wr;
    logic [NUM_CMP-1:0]    sel_cmp, sel_ivl, match;
    logic [31:0]           ctrl_rd;
    logic [5:0]            hw_s;

    always_comb begin
        sel_count = (reg_num == 5'd9)  && (sel == 3'd0);
        sel_ctrl  = (reg_num == 5'd22) && (sel == 3'd7);
        sel_cmp   = '0;
        sel_ivl   = '0;
        for (int i = 0; i < NUM_CMP; i++) begin
            sel_cmp[i] = (reg_num == 5'd11) && (sel == 3'(i));
            sel_ivl[i] = (reg_num == 5'd22) && (sel == 3'(i));
        end
    end

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[NUM_CMP-1:0]  = enable_q;
        ctrl_rd[8 +: NUM_CMP] = pending_q;
        ctrl_rd[31]           = freeze_q;
    end

    always_comb begin
        reg_out = '0;
        reg_hit = 1'b0;
        if (sel_count) begin
            reg_out = count_q;
            reg_hit = 1'b1;
        end
        if (sel_ctrl) begin
            reg_out = ctrl_rd;
            reg_hit = 1'b1;
        end
        for (int i = 0; i < NUM_CMP; i++) begin
            if (sel_cmp[i]) begin
                reg_out = compare_q[i];
                reg_hit = 1'b1;
            end
            if (sel_ivl[i]) begin
                reg_out = interval_q[i];
                reg_hit = 1'b1;
            end
        end
    end

    always_comb begin
        hw_s = '0;
        hw_s[NUM_HW_INT-1:0] = sync_q[SYNC_STAGES-1];
    end

    // A COUNT write wins over the prescaler and suppresses matches on the old value.
    always_comb begin
        count_wr   = wen & sel_count;
        count_d    = count_q;
        div_d      = div_q;
        compare_d  = compare_q;
        interval_d = interval_q;
        enable_d   = enable_q;
        pending_d  = pending_q;
        freeze_d   = freeze_q;
        match      = '0;

        if (count_wr) begin
            count_d = reg_in;
            div_d   = '0;
        end else if (!freeze_q) begin
            if (div_q == DIV_LAST) begin
                div_d   = '0;
                count_d = count_q + 32'd1;
            end else begin
                div_d = div_q + DIV_ONE;
            end
        end

        for (int i = 0; i < NUM_CMP; i++) begin
            match[i] = enable_q[i] && (count_q == compare_q[i]) && (div_q == '0)
                       && !freeze_q && !count_wr;
            if (wen && sel_cmp[i]) begin
                compare_d[i] = reg_in;
                pending_d[i] = 1'b0;
            end else if (match[i]) begin
                pending_d[i] = 1'b1;
                if (interval_q[i] != '0) begin
                    compare_d[i] = compare_q[i] + interval_q[i];
                end
            end
            if (wen && sel_ivl[i]) begin
                interval_d[i] = reg_in;
            end
        end

        if (wen && sel_ctrl) begin
            enable_d = reg_in[NUM_CMP-1:0];
            freeze_d = reg_in[31];
        end

        ip_d = {hw_s[5] | ti, hw_s[4:0], sw_ip};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            div_q     <= '0;
            enable_q  <= NUM_CMP'(1);
            pending_q <= '0;
            freeze_q  <= 1'b0;
            ip_q      <= '0;
            for (int i = 0; i < NUM_CMP; i++) begin
                compare_q[i]  <= '0;
                interval_q[i] <= '0;
            end
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            count_q    <= count_d;
            div_q      <= div_d;
            compare_q  <= compare_d;
            interval_q <= interval_d;
            enable_q   <= enable_d;
            pending_q  <= pending_d;
            freeze_q   <= freeze_d;
            ip_q       <= ip_d;
            sync_q[0]  <= hw_int;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign ti      = |pending_q;
    assign ip_out  = ip_q;
    assign int_req = status_ie & ~status_exl & (|(ip_q & status_im));

endmodule

// File: tb/tb_cp0_timer_irq.sv
// Bench for cp0_timer_irq: directed timer/interrupt scenarios followed by random
// register traffic, all compared each cycle against a count-from-elapsed-time model.
module tb_cp0_timer_irq;

    localparam int NUM_CMP     = 2;
    localparam int COUNT_DIV   = 2;
    localparam int NUM_HW_INT  = 6;
    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        reset, wen;
    logic [4:0]  reg_num;
    logic [2:0]  sel;
    logic [31:0] reg_in, reg_out;
    logic        reg_hit;
    logic [5:0]  hw_int;
    logic [1:0]  sw_ip;
    logic [7:0]  status_im;
    logic        status_ie, status_exl;
    logic [7:0]  ip_out;
    logic        ti, int_req;

    int checks = 0;
    int errors = 0;

    cp0_timer_irq #(
        .NUM_CMP(NUM_CMP), .COUNT_DIV(COUNT_DIV),
        .NUM_HW_INT(NUM_HW_INT), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .reset(reset), .wen(wen), .reg_num(reg_num), .sel(sel),
        .reg_in(reg_in), .reg_out(reg_out), .reg_hit(reg_hit), .hw_int(hw_int),
        .sw_ip(sw_ip), .status_im(status_im), .status_ie(status_ie),
        .status_exl(status_exl), .ip_out(ip_out), .ti(ti), .int_req(int_req)
    );

    always #5 clk = ~clk;

    // Model: COUNT = base + (unfrozen cycles since last COUNT write) / COUNT_DIV.
    logic [31:0]        m_base;
    int unsigned        m_run;
    logic [31:0]        m_cmp [NUM_CMP];
    logic [31:0]        m_ivl [NUM_CMP];
    logic [NUM_CMP-1:0] m_en, m_pend;
    logic               m_frz;
    logic [7:0]         m_ip;
    logic [5:0]         hw_q[$];

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_run / COUNT_DIV);
    endfunction

    function automatic int unsigned m_div();
        return m_run % COUNT_DIV;
    endfunction

    task automatic m_reset();
        m_base = '0;
        m_run  = 0;
        for (int i = 0; i < NUM_CMP; i++) begin
            m_cmp[i] = '0;
            m_ivl[i] = '0;
        end
        m_en   = NUM_CMP'(1);
        m_pend = '0;
        m_frz  = 1'b0;
        m_ip   = '0;
        hw_q.delete();
        repeat (SYNC_STAGES) hw_q.push_back(6'd0);
    endtask

    task automatic m_read(input logic [4:0] r, input logic [2:0] s,
                          output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (r == 5'd9 && s == 3'd0) begin
            hit = 1'b1;
            d   = m_count();
        end else if (r == 5'd11 && int'(s) < NUM_CMP) begin
            hit = 1'b1;
            d   = m_cmp[int'(s)];
        end else if (r == 5'd22 && int'(s) < NUM_CMP) begin
            hit = 1'b1;
            d   = m_ivl[int'(s)];
        end else if (r == 5'd22 && s == 3'd7) begin
            hit = 1'b1;
            d[NUM_CMP-1:0]  = m_en;
            d[8 +: NUM_CMP] = m_pend;
            d[31]           = m_frz;
        end
    endtask

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic m_edge();
        logic [31:0] cnt;
        logic        cnt_wr, match, any_pend;
        logic [5:0]  hw_used;
        if (reset) begin
            m_reset();
            return;
        end
        cnt      = m_count();
        cnt_wr   = wen && reg_num == 5'd9 && sel == 3'd0;
        any_pend = |m_pend;
        hw_used  = hw_q.pop_front();
        hw_q.push_back(hw_int);
        m_ip = {hw_used[5] | any_pend, hw_used[4:0], sw_ip};
        for (int i = 0; i < NUM_CMP; i++) begin
            match = m_en[i] && cnt == m_cmp[i] && m_div() == 0 && !m_frz && !cnt_wr;
            if (wen && reg_num == 5'd11 && sel == 3'(i)) begin
                m_cmp[i]  = reg_in;
                m_pend[i] = 1'b0;
            end else if (match) begin
                m_pend[i] = 1'b1;
                if (m_ivl[i] != 0) m_cmp[i] = m_cmp[i] + m_ivl[i];
            end
            if (wen && reg_num == 5'd22 && sel == 3'(i)) m_ivl[i] = reg_in;
        end
        if (cnt_wr) begin
            m_base = reg_in;
            m_run  = 0;
        end else if (!m_frz) begin
            m_run++;
        end
        if (wen && reg_num == 5'd22 && sel == 3'd7) begin
            m_en  = reg_in[NUM_CMP-1:0];
            m_frz = reg_in[31];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic        hit;
        logic [31:0] d;
        m_read(reg_num, sel, hit, d);
        chk("reg_out", reg_out, d);
        chk("reg_hit", 32'(reg_hit), 32'(hit));
        chk("ti", 32'(ti), 32'(|m_pend));
        chk("ip_out", 32'(ip_out), 32'(m_ip));
        chk("int_req", 32'(int_req), 32'(status_ie & ~status_exl & (|(m_ip & status_im))));
    endtask

    task automatic tick();
        m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        wen = 1'b0;
        repeat (n) begin
            #1;
            check_outputs();
            tick();
        end
    endtask

    task automatic wr(input logic [4:0] r, input logic [2:0] s, input logic [31:0] d);
        wen = 1'b1; reg_num = r; sel = s; reg_in = d;
        #1;
        check_outputs();
        tick();
        wen = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] r, input logic [2:0] s,
                      input logic [31:0] exp);
        wen = 1'b0; reg_num = r; sel = s;
        #1;
        check_outputs();
        chk(tag, reg_out, exp);
    endtask

    initial begin
        logic [31:0] frz_cnt;
        int          pick, k;

        reset = 1'b1; wen = 1'b0; reg_num = '0; sel = '0; reg_in = '0;
        hw_int = '0; sw_ip = '0; status_im = '0; status_ie = 1'b0; status_exl = 1'b0;
        m_reset();
        tick();
        tick();
        reset = 1'b0;
        rd("reset_count", 5'd9, 3'd0, 32'd0);
        rd("reset_ctrl", 5'd22, 3'd7, 32'h1);
        chk("reset_ip", 32'(ip_out), 32'h0);

        // One-shot match at COUNT 5 with divide-by-2.
        wr(5'd9, 3'd0, 32'd0);
        wr(5'd11, 3'd0, 32'd5);
        idle(9);
        rd("div2_count", 5'd9, 3'd0, 32'd5);
        chk("div2_ti_before", 32'(ti), 32'd0);
        idle(1);
        rd("div2_pending", 5'd22, 3'd7, 32'h101);
        chk("div2_ip7_early", 32'(ip_out[7]), 32'd0);
        idle(1);
        chk("div2_ip7", 32'(ip_out[7]), 32'd1);
        status_im = 8'h80; status_ie = 1'b1; status_exl = 1'b0;
        #1;
        chk("int_req_on", 32'(int_req), 32'd1);
        status_exl = 1'b1;
        #1;
        chk("int_req_exl", 32'(int_req), 32'd0);
        status_exl = 1'b0;
        idle(6);
        rd("div2_once", 5'd22, 3'd7, 32'h101);

        // Periodic reload on channel 1.
        wr(5'd22, 3'd7, 32'h3);
        wr(5'd22, 3'd1, 32'h10);
        wr(5'd11, 3'd1, 32'h10);
        wr(5'd11, 3'd0, 32'hFFFF_0000);
        wr(5'd9, 3'd0, 32'd0);
        idle(32'h62);
        rd("periodic_cmp", 5'd11, 3'd1, 32'h40);
        rd("periodic_ctrl", 5'd22, 3'd7, 32'h203);

        // Wrap through zero.
        wr(5'd22, 3'd7, 32'h1);
        wr(5'd11, 3'd1, 32'hFFFF_0000);
        wr(5'd11, 3'd0, 32'h1);
        wr(5'd9, 3'd0, 32'hFFFF_FFFE);
        idle(4);
        rd("wrap_zero", 5'd9, 3'd0, 32'd0);
        idle(2);
        rd("wrap_one", 5'd9, 3'd0, 32'd1);
        rd("wrap_nopend", 5'd22, 3'd7, 32'h1);
        idle(1);
        rd("wrap_pend", 5'd22, 3'd7, 32'h101);

        // COMPARE write on the exact match cycle.
        wr(5'd11, 3'd0, 32'h10);
        wr(5'd9, 3'd0, 32'hE);
        idle(4);
        wr(5'd11, 3'd0, 32'h30);
        rd("coll_cmp", 5'd11, 3'd0, 32'h30);
        rd("coll_nopend", 5'd22, 3'd7, 32'h1);
        idle(63);
        rd("coll_count", 5'd9, 3'd0, 32'h30);
        idle(1);
        rd("coll_later", 5'd22, 3'd7, 32'h101);

        // Freeze, then COUNT writes.
        wr(5'd22, 3'd7, 32'h8000_0001);
        frz_cnt = m_count();
        wr(5'd11, 3'd0, frz_cnt);
        idle(20);
        rd("frz_hold", 5'd9, 3'd0, frz_cnt);
        rd("frz_nomatch", 5'd22, 3'd7, 32'h8000_0001);
        wr(5'd9, 3'd0, 32'd7);
        rd("cwr_frz", 5'd9, 3'd0, 32'd7);
        wr(5'd22, 3'd7, 32'h1);
        rd("cwr_unfrz", 5'd9, 3'd0, 32'd7);
        idle(1);
        rd("cwr_div1", 5'd9, 3'd0, 32'd7);
        idle(1);
        rd("cwr_inc", 5'd9, 3'd0, 32'd8);
        wr(5'd9, 3'd0, 32'd100);
        rd("cwr_noinc", 5'd9, 3'd0, 32'd100);

        // Hardware interrupt pulse on line 2.
        hw_int = 6'b000100;
        idle(2);
        chk("hw_rise_early", 32'(ip_out[4]), 32'd0);
        idle(1);
        chk("hw_rise", 32'(ip_out[4]), 32'd1);
        idle(1);
        hw_int = '0;
        idle(2);
        chk("hw_fall_early", 32'(ip_out[4]), 32'd1);
        idle(1);
        chk("hw_fall", 32'(ip_out[4]), 32'd0);
        rd("unmapped", 5'd22, 3'd5, 32'd0);
        chk("unmapped_hit", 32'(reg_hit), 32'd0);

        // Random register traffic, interrupts and an occasional mid-run reset.
        repeat (600) begin
            hw_int     = 6'($urandom);
            sw_ip      = 2'($urandom);
            status_im  = 8'($urandom);
            status_ie  = 1'($urandom);
            status_exl = ($urandom_range(0, 3) == 0);
            reset      = ($urandom_range(0, 249) == 0);
            wen        = 1'b0;
            pick       = $urandom_range(0, 9);
            k          = $urandom_range(0, NUM_CMP - 1);
            case (pick)
                0: begin
                    wen = 1'b1; reg_num = 5'd9; sel = 3'd0;
                    reg_in = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                         : m_cmp[k] - 32'($urandom_range(0, 6));
                end
                1, 2: begin
                    wen = 1'b1; reg_num = 5'd11; sel = 3'(k);
                    reg_in = m_count() + 32'($urandom_range(0, 10));
                end
                3: begin
                    wen = 1'b1; reg_num = 5'd22; sel = 3'(k);
                    reg_in = 32'($urandom_range(0, 4));
                end
                4: begin
                    wen = 1'b1; reg_num = 5'd22; sel = 3'd7;
                    reg_in = {($urandom_range(0, 3) == 0), 23'd0, 8'($urandom)};
                end
                5: begin
                    reg_num = 5'($urandom); sel = 3'($urandom);
                end
                default: begin
                    case ($urandom_range(0, 2))
                        0: reg_num = 5'd9;
                        1: reg_num = 5'd11;
                        default: reg_num = 5'd22;
                    endcase
                    sel = 3'($urandom);
                end
            endcase
            #1;
            check_outputs();
            tick();
            reset = 1'b0;
            wen   = 1'b0;
        end
        #1;
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_timer_irq.md
Name: cp0_timer_irq

Overview:
- Parametrised successor of the CP0 Count/Compare and interrupt-pending logic.
- Provides one free-running Count with a programmable prescaler, NUM_CMP compare channels with optional periodic auto-reload, and hardware-interrupt synchronisers.
- Produces Cause.IP[7:0] and a gated interrupt request for WB.
- Sits beside the CP0 register file, which muxes this block's `reg_out` in when `reg_hit` is high.

Parameters:
- NUM_CMP, 2, compare channels (1..4).
- COUNT_DIV, 2, clk cycles per Count increment (>=1).
- NUM_HW_INT, 6, hardware interrupt lines (1..6); missing lines read as 0.
- SYNC_STAGES, 2, synchroniser flops per hw line (>=2).

Ports:
- clk  in  1  clock; reset is synchronous, active-high, on `reset`
- reset  in  1  reset
- wen  in  1  MTC0 write strobe from WB
- reg_num  in  5  CP0 register number
- sel  in  3  CP0 select
- reg_in  in  32  write data
- reg_out  out  32  read data, combinational
- reg_hit  out  1  reg_num/sel decodes to a register owned here
- hw_int  in  NUM_HW_INT  asynchronous interrupt lines
- sw_ip  in  2  Cause.IP[1:0] from CP0
- status_im  in  8  Status.IM
- status_ie  in  1  Status.IE
- status_exl  in  1  Status.EXL
- ip_out  out  8  Cause.IP view
- ti  out  1  OR of channel pending bits (Cause.TI)
- int_req  out  1  interrupt request to WB

Behaviour:

Register map:
- reg 9 sel 0: COUNT.
- reg 11 sel n (n<NUM_CMP): COMPARE_n.
- reg 22 sel n: INTERVAL_n.
- reg 22 sel 7: CTRL.
  - [NUM_CMP-1:0] channel enable.
  - [8+NUM_CMP-1:8] pending bits; read only, write ignored.
  - [31] freeze.
- Any other reg/sel: `reg_hit`=0, `reg_out`=0.

Reset values:
- COUNT=0, prescaler=0.
- COMPARE_n=0, INTERVAL_n=0.
- enable=1 for channel 0 only; freeze=0; pending=0.
- Synchronisers 0; `ip_out`=0, `ti`=0, `int_req`=0.

Prescaler:
- `div_cnt` runs 0..COUNT_DIV-1 and wraps.
- COUNT increments, modulo 2^32 (0xFFFFFFFF->0), on the cycle `div_cnt`==COUNT_DIV-1.
- Freeze=1 holds both COUNT and `div_cnt`.
- COUNT_DIV=1: COUNT increments every unfrozen cycle.

COUNT write:
- COUNT<=reg_in and `div_cnt`<=0.
- Overrides the increment in the same cycle.

Match_n:
- Condition: enable_n & (COUNT==COMPARE_n) & (`div_cnt`==0) & ~freeze & ~(COUNT write this cycle).
- At most one match per COUNT value.
- On match: pending_n<=1, registered (visible the next cycle).
- If INTERVAL_n!=0: COMPARE_n<=COMPARE_n+INTERVAL_n (mod 2^32) in the same edge.
- If INTERVAL_n==0: one-shot; COMPARE_n holds.

COMPARE_n write:
- COMPARE_n<=reg_in and pending_n<=0.
- Beats a same-cycle match and reload.

INTERVAL_n write:
- Takes effect from the next match.

Channel disable:
- Clearing an enable bit stops matches but leaves pending as-is.
- Pending clears only via a COMPARE_n write or reset.

Synchronisers and outputs:
- `ti` = |pending, combinational from the registers.
- Each `hw_int` passes through SYNC_STAGES flops.
- `ip_out` is registered each cycle:
  - [7] = hw_s[5] | ti
  - [6:2] = hw_s[4:0]
  - [1:0] = sw_ip
- `int_req` = status_ie & ~status_exl & |(ip_out & status_im), combinational.

Latency:
- Match to `ip_out`[7]: 2 cycles.
- `hw_int` rise to `ip_out`: SYNC_STAGES+1 cycles.

Reset mid-count:
- Everything returns to reset values; a pending timer interrupt is lost.

Test Plan:
- Div 2: reset, write COMPARE_0=5 -> COUNT reaches 5 after 10 cycles; pending_0 set once; `ip_out`[7]=1 two cycles after the match; `int_req`=1 with IM=0x80, IE=1, EXL=0; `int_req`=0 when EXL=1.
- Periodic: COMPARE_1=0x10, INTERVAL_1=0x10, enable=0b11 -> matches at COUNT 0x10, 0x20, 0x30; COMPARE_1 reads 0x40 after the third match.
- Wrap: COUNT=0xFFFFFFFE, COMPARE_0=0x00000001 -> COUNT wraps to 0; match at 1; pending set.
- Collision: write COMPARE_0 on the exact match cycle -> pending_0 stays 0; the new value is stored; a later match on the new value fires normally.
- Freeze and COUNT write: set CTRL[31] -> COUNT holds for 20 cycles with no match even when equal; write COUNT=7 -> COUNT=7 and `div_cnt`=0, with no increment in that cycle.
- HW interrupt: pulse hw_int[2] high for 4 cycles with SYNC_STAGES=2 -> `ip_out`[4] rises 3 cycles later and falls 3 cycles after the deassert; an unmapped reg 22 sel 5 read returns 0 with `reg_hit`=0.
